// File: rtl/ldlt_seq_pkg.sv
// Shared types for the LDLT job sequencer: FSM states, response codes and
// the latched job descriptor.
package ldlt_seq_pkg;

   localparam int DESC_DIM_W = 8;
   localparam int DESC_AW    = 16;
   localparam int TOTAL_W    = 2*DESC_DIM_W + 1;
   localparam int DATA_W     = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_START,
      ST_LOAD,
      ST_COLLECT,
      ST_RESP
   } seq_state_e;

   typedef enum logic [1:0] {
      ERR_OK      = 2'd0,
      ERR_BAD     = 2'd1,
      ERR_TIMEOUT = 2'd2
   } resp_err_e;

   typedef struct packed {
      logic [DESC_DIM_W-1:0] rows;
      logic [DESC_DIM_W-1:0] cols;
      logic [DESC_AW-1:0]    src;
      logic [DESC_AW-1:0]    dst;
   } job_desc_t;

   // Input word count rows*cols+rows, wide enough that it never wraps.
   function automatic logic [TOTAL_W-1:0] job_total(input logic [DESC_DIM_W-1:0] rows,
                                                    input logic [DESC_DIM_W-1:0] cols);
      logic [TOTAL_W-1:0] prod;
      prod = TOTAL_W'(rows) * TOTAL_W'(cols);
      return prod + TOTAL_W'(rows);
   endfunction

endpackage

// File: rtl/ldlt_stream_fifo.sv
// Two-entry valid/ready FIFO between scratchpad read data and the core's
// input stream; flush drops all contents.
module ldlt_stream_fifo #(
   parameter int W = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         flush,
   input  logic         push_valid,
   input  logic [W-1:0] push_data,
   input  logic         pop_ready,
   output logic         pop_valid,
   output logic [W-1:0] pop_data,
   output logic [1:0]   count
);

   logic [1:0][W-1:0] mem_q;
   logic              wr_ptr_q;
   logic              rd_ptr_q;
   logic [1:0]        cnt_q;
   logic              push;
   logic              pop;

   assign push      = push_valid && (cnt_q != 2'd2);
   assign pop       = pop_ready && (cnt_q != 2'd0);
   assign pop_valid = (cnt_q != 2'd0);
   assign pop_data  = mem_q[rd_ptr_q];
   assign count     = cnt_q;

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/ldlt_job_sequencer.sv
// Runs one LDLT solve job: validates the descriptor, starts the core,
// streams A then b from scratchpad, writes x back and posts a response.
module ldlt_job_sequencer
   import ldlt_seq_pkg::*;
#(
   parameter int AW        = DESC_AW,
   parameter int DIM_W     = DESC_DIM_W,
   parameter int MAX_WORDS = 1024,
   parameter int TIMEOUT   = 4096
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DIM_W-1:0]  cmd_rows,
   input  logic [DIM_W-1:0]  cmd_cols,
   input  logic [AW-1:0]     cmd_src_addr,
   input  logic [AW-1:0]     cmd_dst_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [1:0]        resp_err,
   output logic              mem_rd_en,
   output logic [AW-1:0]     mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              mem_wr_en,
   output logic [AW-1:0]     mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              acc_start,
   input  logic              acc_busy,
   input  logic              acc_done,
   output logic [63:0]       acc_rows,
   output logic [63:0]       acc_cols,
   output logic [DATA_W-1:0] acc_in_data,
   output logic              acc_in_valid,
   input  logic              acc_in_ready,
   input  logic [DATA_W-1:0] acc_out_data,
   input  logic              acc_out_valid,
   output logic              acc_out_ready
);

   localparam int                  WD_W    = $clog2(TIMEOUT + 1);
   localparam logic [TOTAL_W-1:0]  MAX_T   = TOTAL_W'(MAX_WORDS);
   localparam logic [WD_W-1:0]     WD_LAST = WD_W'(TIMEOUT - 1);

   seq_state_e          state_q, state_d;
   resp_err_e           err_q, err_d;
   job_desc_t           desc_q;
   logic [TOTAL_W-1:0]  total_q, total_c;
   logic [TOTAL_W-1:0]  rd_cnt_q, pop_cnt_q;
   logic [DIM_W-1:0]    wr_cnt_q;
   logic [WD_W-1:0]     wd_q;
   logic                rd_inflight_q;

   logic                rd_issue;
   logic                fifo_flush;
   logic                fifo_push;
   logic                fifo_valid;
   logic [DATA_W-1:0]   fifo_data;
   logic [1:0]          fifo_cnt;
   logic                fifo_room;
   logic                pop;
   logic                beat;
   logic                in_stream;
   logic                wd_expire;
   logic                desc_bad;

   // Core status is informational; completion is counted on result beats.
   logic unused_ok;
   assign unused_ok = &{1'b0, acc_busy, acc_done};

   assign total_c   = job_total(desc_q.rows, desc_q.cols);
   assign desc_bad  = (desc_q.rows == '0) || (desc_q.cols == '0) || (total_c > MAX_T);

   assign in_stream    = (state_q == ST_LOAD);
   assign acc_in_valid = fifo_valid && in_stream;
   assign acc_in_data  = acc_in_valid ? fifo_data : '0;
   assign pop          = acc_in_valid && acc_in_ready;
   assign beat         = acc_out_valid && (state_q == ST_COLLECT);
   assign wd_expire    = !(pop || beat) && (wd_q == WD_LAST);

   // Free slots must cover the read already in flight before another issues.
   assign fifo_room = ({1'b0, fifo_cnt} + {2'b00, rd_inflight_q}) < 3'd2;
   assign fifo_push = rd_inflight_q && in_stream;

   assign mem_rd_en   = rd_issue;
   assign mem_rd_addr = rd_issue ? desc_q.src + rd_cnt_q[AW-1:0] : '0;
   assign mem_wr_en   = beat;
   assign mem_wr_addr = beat ? desc_q.dst + AW'(wr_cnt_q) : '0;
   assign mem_wr_data = beat ? acc_out_data : '0;
   assign acc_rows    = 64'(desc_q.rows);
   assign acc_cols    = 64'(desc_q.cols);
   assign resp_err    = err_q;

   ldlt_stream_fifo #(.W(DATA_W)) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .flush      (fifo_flush),
      .push_valid (fifo_push),
      .push_data  (mem_rd_data),
      .pop_ready  (acc_in_ready && in_stream),
      .pop_valid  (fifo_valid),
      .pop_data   (fifo_data),
      .count      (fifo_cnt)
   );

   always_comb begin
      state_d       = state_q;
      err_d         = err_q;
      cmd_ready     = 1'b0;
      resp_valid    = 1'b0;
      acc_start     = 1'b0;
      acc_out_ready = 1'b0;
      rd_issue      = 1'b0;
      fifo_flush    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready  = 1'b1;
            fifo_flush = 1'b1;
            if (cmd_valid) begin
               state_d = ST_CHECK;
               err_d   = ERR_OK;
            end
         end
         ST_CHECK: begin
            if (desc_bad) begin
               state_d = ST_RESP;
               err_d   = ERR_BAD;
            end else begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            acc_start = 1'b1;
            state_d   = ST_LOAD;
         end
         ST_LOAD: begin
            rd_issue = (rd_cnt_q != total_q) && fifo_room && !wd_expire;
            if (pop && (pop_cnt_q == total_q - TOTAL_W'(1))) begin
               state_d = ST_COLLECT;
            end else if (wd_expire) begin
               state_d    = ST_RESP;
               err_d      = ERR_TIMEOUT;
               fifo_flush = 1'b1;
            end
         end
         ST_COLLECT: begin
            acc_out_ready = 1'b1;
            if (beat && (wr_cnt_q == desc_q.rows - DIM_W'(1))) begin
               state_d = ST_RESP;
            end else if (wd_expire) begin
               state_d    = ST_RESP;
               err_d      = ERR_TIMEOUT;
               fifo_flush = 1'b1;
            end
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         err_q         <= ERR_OK;
         desc_q        <= '0;
         total_q       <= '0;
         rd_cnt_q      <= '0;
         pop_cnt_q     <= '0;
         wr_cnt_q      <= '0;
         wd_q          <= '0;
         rd_inflight_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         err_q         <= err_d;
         rd_inflight_q <= rd_issue;
         if ((state_q == ST_IDLE) && cmd_valid) begin
            desc_q <= '{rows: cmd_rows, cols: cmd_cols, src: cmd_src_addr, dst: cmd_dst_addr};
         end
         if (state_q == ST_CHECK) begin
            total_q   <= total_c;
            rd_cnt_q  <= '0;
            pop_cnt_q <= '0;
            wr_cnt_q  <= '0;
         end else begin
            if (rd_issue) rd_cnt_q  <= rd_cnt_q + TOTAL_W'(1);
            if (pop)      pop_cnt_q <= pop_cnt_q + TOTAL_W'(1);
            if (beat)     wr_cnt_q  <= wr_cnt_q + DIM_W'(1);
         end
         if (((state_q == ST_LOAD) || (state_q == ST_COLLECT)) && !(pop || beat)) begin
            wd_q <= wd_q + WD_W'(1);
         end else begin
            wd_q <= '0;
         end
      end
   end

endmodule
